// File: rtl/lane_sel_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | lane_sel_pkg : shared FSM state type and tag match constant       |
// | Revision 1.0                                                      |
// +-------------------------------------------------------------------+
package lane_sel_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } state_t;

  // Wide enough for any supported tag; decoders slice off TAG_W bits.
  localparam int                   TAG_MAX_W    = 32;
  localparam logic [TAG_MAX_W-1:0] TAG_ALL_ONES = '1;

endpackage
`default_nettype wire

// File: rtl/lane_hdr_decode.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | lane_hdr_decode : per-lane tag hit and zero-length (eof) detect   |
// | Revision 1.0                                                      |
// +-------------------------------------------------------------------+
module lane_hdr_decode
  import lane_sel_pkg::*;
#(
  parameter int LANE_W = 64,
  parameter int TAG_W  = 3,
  parameter int LEN_W  = 5
) (
  input  logic [LANE_W-1:0] lane,
  output logic              hit,
  output logic              eof_hit
);

  logic [TAG_W-1:0] tag;
  logic [LEN_W-1:0] len;
  logic             unused_payload;

  assign tag            = lane[LANE_W-1 -: TAG_W];
  assign len            = lane[LANE_W-TAG_W-1 -: LEN_W];
  assign unused_payload = ^lane[LANE_W-TAG_W-LEN_W-1:0];

  assign hit     = (tag == TAG_ALL_ONES[TAG_W-1:0]);
  assign eof_hit = hit && (len == '0);

endmodule
`default_nettype wire

// File: rtl/lane_selector_pipe.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | lane_selector_pipe : lane header scan with frame tracking         |
// | Optional macro LANE_SELECTOR_STATS_EN adds frame_total counter.   |
// | Revision 1.0                                                      |
// +-------------------------------------------------------------------+
module lane_selector_pipe
  import lane_sel_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int LANE_W = 64,
  parameter int TAG_W  = 3,
  parameter int LEN_W  = 5,
  parameter int FLEN_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*LANE_W-1:0]      in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES-1:0]             found,
  output logic [$clog2(LANES+1)-1:0]   hit_cnt,
  output logic [$clog2(LANES)-1:0]     first_idx,
  output logic                         eof,
`ifdef LANE_SELECTOR_STATS_EN
  output logic [FLEN_W-1:0]            frame_len,
  output logic [31:0]                  frame_total
`else
  output logic [FLEN_W-1:0]            frame_len
`endif
);

  localparam int               CNT_W    = $clog2(LANES+1);
  localparam int               IDX_W    = $clog2(LANES);
  localparam logic [FLEN_W-1:0] FLEN_MAX = '1;

  logic [LANES-1:0]  hit_vec;
  logic [LANES-1:0]  eof_vec;
  logic              accept;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [IDX_W-1:0]  idx_nxt;
  logic              eof_nxt;

  state_t            state;
  state_t            state_nxt;
  logic [FLEN_W-1:0] word_cnt;
  logic [FLEN_W-1:0] word_cnt_nxt;
  logic [FLEN_W-1:0] cnt_inc;
  logic [FLEN_W-1:0] flen_nxt;

  // Vector bit LANES-1-i belongs to lane i, matching the in_data layout.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_hdr_decode #(
      .LANE_W (LANE_W),
      .TAG_W  (TAG_W),
      .LEN_W  (LEN_W)
    ) u_dec (
      .lane    (in_data[(LANES-1-i)*LANE_W +: LANE_W]),
      .hit     (hit_vec[LANES-1-i]),
      .eof_hit (eof_vec[LANES-1-i])
    );
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign eof_nxt  = |eof_vec;

  // Walk from the highest lane down so the lowest-numbered hit wins.
  always_comb begin
    cnt_nxt = '0;
    idx_nxt = '0;
    for (int i = LANES-1; i >= 0; i--) begin
      if (hit_vec[LANES-1-i]) begin
        cnt_nxt = cnt_nxt + CNT_W'(1);
        idx_nxt = IDX_W'(i);
      end
    end
  end

  assign cnt_inc = (word_cnt == FLEN_MAX) ? FLEN_MAX : word_cnt + FLEN_W'(1);

  always_comb begin
    state_nxt    = state;
    word_cnt_nxt = word_cnt;
    flen_nxt     = '0;
    if (accept) begin
      case (state)
        ST_IDLE: begin
          if (eof_nxt) begin
            flen_nxt = FLEN_W'(1);
          end else if (|hit_vec) begin
            state_nxt    = ST_FRAME;
            word_cnt_nxt = FLEN_W'(1);
          end
        end
        ST_FRAME: begin
          // Hits after the eof lane never reopen a frame.
          if (eof_nxt) begin
            flen_nxt     = cnt_inc;
            state_nxt    = ST_IDLE;
            word_cnt_nxt = '0;
          end else begin
            word_cnt_nxt = cnt_inc;
          end
        end
        default: begin
          state_nxt    = ST_IDLE;
          word_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      word_cnt <= '0;
    end else begin
      state    <= state_nxt;
      word_cnt <= word_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      found     <= '0;
      hit_cnt   <= '0;
      first_idx <= '0;
      eof       <= 1'b0;
      frame_len <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      found     <= hit_vec;
      hit_cnt   <= cnt_nxt;
      first_idx <= idx_nxt;
      eof       <= eof_nxt;
      frame_len <= flen_nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef LANE_SELECTOR_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_total <= '0;
    end else if (accept && eof_nxt) begin
      frame_total <= frame_total + 32'd1;
    end
  end
`else
`endif

endmodule
`default_nettype wire
